// File: rtl/calc_core.sv
// calc_core: keypad-driven +,-,*,/ calculator with shift-add multiply, restoring divide and
// double-dabble conversion. Define CALC_DIV_FRAC_EN to show one fractional digit on divide.
module calc_core #(
    parameter int DIGITS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [39:0] seg_data,
    output logic [7:0]  seg_data_en,
    output logic [7:0]  seg_dot_en,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam int OPW  = $clog2(10 ** DIGITS);
    localparam int RW   = 2 * OPW + 4;
    localparam int NBCD = 2 * DIGITS + 1;
    localparam int CW   = $clog2(RW + 1);
`ifdef CALC_DIV_FRAC_EN
    localparam bit FracEn = 1'b1;
`else
    localparam bit FracEn = 1'b0;
`endif

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StAIn  = 3'd1;
    localparam logic [2:0] StOp   = 3'd2;
    localparam logic [2:0] StBIn  = 3'd3;
    localparam logic [2:0] StCalc = 3'd4;
    localparam logic [2:0] StConv = 3'd5;
    localparam logic [2:0] StShow = 3'd6;
    localparam logic [2:0] StErr  = 3'd7;

    localparam logic [1:0] OpAdd = 2'd0;
    localparam logic [1:0] OpSub = 2'd1;
    localparam logic [1:0] OpMul = 2'd2;
    localparam logic [1:0] OpDiv = 2'd3;

    logic [2:0]                state_q;
    logic [OPW-1:0]            a_q, b_q, mplier_q, rem_q;
    logic [DIGITS-1:0][3:0]    a_bcd_q, b_bcd_q;
    logic [1:0]                a_cnt_q, b_cnt_q, op_q;
    logic [RW-1:0]             work_q, acc_q;
    logic [CW-1:0]             cnt_q;
    logic [NBCD-1:0][3:0]      bcd_q;
    logic                      neg_q, frac_q, done_q;

    logic kd, ko, ke, kc;
    assign kd = key_valid && (key_code <= 4'd9);
    assign ko = key_valid && (key_code >= 4'ha) && (key_code <= 4'hd);
    assign ke = key_valid && (key_code == 4'he);
    assign kc = key_valid && (key_code == 4'hf);

    // One double-dabble step: add 3 to digits >= 5, then shift in the next binary bit.
    function automatic logic [4*NBCD-1:0] dd_step(input logic [4*NBCD-1:0] v, input logic b);
        logic [4*NBCD-1:0] t;
        t = v;
        for (int i = 0; i < NBCD; i++) begin
            if (v[4*i +: 4] >= 4'd5) t[4*i +: 4] = v[4*i +: 4] + 4'd3;
        end
        return (t << 1) | {{(4*NBCD-1){1'b0}}, b};
    endfunction

    logic [RW-1:0]  acc_next, div_q, calc_res, calc_mag;
    logic [OPW:0]   div_sh;
    logic [OPW-1:0] div_rem;
    logic           div_ge, calc_last, calc_neg;

    always_comb begin
        acc_next  = acc_q + (mplier_q[0] ? work_q : '0);
        div_sh    = {rem_q, work_q[RW-1]};
        div_ge    = div_sh >= {1'b0, b_q};
        div_rem   = div_ge ? OPW'(div_sh - {1'b0, b_q}) : div_sh[OPW-1:0];
        div_q     = {work_q[RW-2:0], div_ge};
        calc_res  = '0;
        calc_last = 1'b0;
        case (op_q)
            OpAdd: begin
                calc_res  = RW'(a_q) + RW'(b_q);
                calc_last = 1'b1;
            end
            OpSub: begin
                calc_res  = RW'(a_q) - RW'(b_q);
                calc_last = 1'b1;
            end
            OpMul: begin
                calc_res  = acc_next;
                calc_last = (cnt_q == CW'(OPW - 1));
            end
            default: begin
                calc_res  = div_q;
                calc_last = (cnt_q == CW'(RW - 1));
            end
        endcase
        calc_neg = (op_q == OpSub) && calc_res[RW-1];
        calc_mag = calc_neg ? -calc_res : calc_res;
    end

    // Chaining: integer part of the shown result, valid only if it fits an operand.
    logic [NBCD-1:0][3:0]   int_bcd;
    logic [OPW-1:0]         chain_bin;
    logic [1:0]             chain_cnt;
    logic                   chain_ok;

    always_comb begin
        int_bcd  = frac_q ? (bcd_q >> 4) : bcd_q;
        chain_ok = !neg_q;
        for (int i = DIGITS; i < NBCD; i++) begin
            if (int_bcd[i] != 4'd0) chain_ok = 1'b0;
        end
        chain_bin = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            chain_bin = chain_bin * OPW'(10) + OPW'(int_bcd[i]);
        end
        chain_cnt = 2'd1;
        for (int i = 1; i < DIGITS; i++) begin
            if (int_bcd[i] != 4'd0) chain_cnt = 2'(i + 1);
        end
    end

    always_ff @(posedge clk) begin
        done_q <= 1'b0;
        if (!rst_n || kc) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            a_bcd_q  <= '0;
            b_bcd_q  <= '0;
            a_cnt_q  <= '0;
            b_cnt_q  <= '0;
            op_q     <= OpAdd;
            work_q   <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            bcd_q    <= '0;
            neg_q    <= 1'b0;
            frac_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StShow: begin
                    if (kd) begin
                        a_q     <= OPW'(key_code);
                        a_bcd_q <= (4*DIGITS)'(key_code);
                        a_cnt_q <= 2'd1;
                        b_q     <= '0;
                        b_bcd_q <= '0;
                        b_cnt_q <= '0;
                        neg_q   <= 1'b0;
                        frac_q  <= 1'b0;
                        state_q <= StAIn;
                    end else if (ko) begin
                        op_q    <= 2'(key_code - 4'ha);
                        b_q     <= '0;
                        b_bcd_q <= '0;
                        b_cnt_q <= '0;
                        if (state_q == StIdle) begin
                            a_q     <= '0;
                            a_bcd_q <= '0;
                            a_cnt_q <= 2'd1;
                            state_q <= StOp;
                        end else if (chain_ok) begin
                            a_q     <= chain_bin;
                            a_bcd_q <= int_bcd[DIGITS-1:0];
                            a_cnt_q <= chain_cnt;
                            state_q <= StOp;
                        end else begin
                            state_q <= StErr;
                        end
                    end
                end
                StAIn: begin
                    if (kd && a_cnt_q < 2'(DIGITS)) begin
                        a_q     <= a_q * OPW'(10) + OPW'(key_code);
                        a_bcd_q <= (a_bcd_q << 4) | (4*DIGITS)'(key_code);
                        a_cnt_q <= a_cnt_q + 2'd1;
                    end else if (ko) begin
                        op_q    <= 2'(key_code - 4'ha);
                        b_q     <= '0;
                        b_bcd_q <= '0;
                        b_cnt_q <= '0;
                        state_q <= StOp;
                    end
                end
                StOp: begin
                    if (ko) begin
                        op_q <= 2'(key_code - 4'ha);
                    end else if (kd) begin
                        b_q     <= OPW'(key_code);
                        b_bcd_q <= (4*DIGITS)'(key_code);
                        b_cnt_q <= 2'd1;
                        state_q <= StBIn;
                    end
                end
                StBIn: begin
                    if (kd && b_cnt_q < 2'(DIGITS)) begin
                        b_q     <= b_q * OPW'(10) + OPW'(key_code);
                        b_bcd_q <= (b_bcd_q << 4) | (4*DIGITS)'(key_code);
                        b_cnt_q <= b_cnt_q + 2'd1;
                    end else if (ke) begin
                        acc_q    <= '0;
                        mplier_q <= b_q;
                        rem_q    <= '0;
                        cnt_q    <= '0;
                        frac_q   <= FracEn && (op_q == OpDiv);
                        if (op_q == OpDiv && FracEn) work_q <= RW'(a_q) * RW'(10);
                        else                         work_q <= RW'(a_q);
                        state_q <= StCalc;
                    end
                end
                StCalc: begin
                    if (op_q == OpDiv && b_q == '0) begin
                        state_q <= StErr;
                    end else begin
                        acc_q    <= acc_next;
                        mplier_q <= mplier_q >> 1;
                        rem_q    <= div_rem;
                        work_q   <= (op_q == OpMul) ? (work_q << 1) : div_q;
                        cnt_q    <= cnt_q + CW'(1);
                        if (calc_last) begin
                            neg_q   <= calc_neg;
                            work_q  <= calc_mag;
                            bcd_q   <= '0;
                            cnt_q   <= '0;
                            state_q <= StConv;
                        end
                    end
                end
                StConv: begin
                    bcd_q  <= dd_step(bcd_q, work_q[RW-1]);
                    work_q <= work_q << 1;
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == CW'(RW - 1)) begin
                        done_q  <= 1'b1;
                        state_q <= StShow;
                    end
                end
                default: ;
            endcase
        end
    end

    logic [4:0]             disp [8];
    logic [DIGITS-1:0][3:0] ent_bcd;
    logic [1:0]             ent_cnt;
    int                     msd;

    always_comb begin
        for (int i = 0; i < 8; i++) disp[i] = 5'd16;
        ent_bcd = a_bcd_q;
        ent_cnt = a_cnt_q;
        msd     = 0;
        case (state_q)
            StAIn, StOp, StBIn, StCalc, StConv: begin
                if (state_q != StAIn) begin
                    case (op_q)
                        OpAdd:   disp[0] = 5'd10;
                        OpSub:   disp[0] = 5'd12;
                        OpMul:   disp[0] = 5'd13;
                        default: disp[0] = 5'd14;
                    endcase
                    if (b_cnt_q != 2'd0) begin
                        ent_bcd = b_bcd_q;
                        ent_cnt = b_cnt_q;
                    end
                end
                for (int i = 0; i < DIGITS; i++) begin
                    if (i < int'(ent_cnt)) disp[7-i] = {1'b0, ent_bcd[i]};
                end
            end
            StShow: begin
                disp[0] = 5'd18;
                for (int i = 0; i < NBCD; i++) begin
                    if (bcd_q[i] != 4'd0) msd = i;
                end
                if (frac_q && msd < 1) msd = 1;
                for (int i = 0; i < NBCD; i++) begin
                    if (i <= msd) disp[7-i] = {1'b0, bcd_q[i]};
                end
                for (int i = 1; i < 7; i++) begin
                    if (neg_q && i == msd + 1) disp[7-i] = 5'd12;
                end
            end
            StErr: begin
                disp[5] = 5'd15;
                disp[6] = 5'd17;
                disp[7] = 5'd17;
            end
            default: ;
        endcase
        for (int i = 0; i < 8; i++) seg_data[5*i +: 5] = disp[i];
    end

    assign seg_data_en = 8'hff;
    assign seg_dot_en  = (state_q == StShow && frac_q) ? 8'h40 : 8'h00;
    assign busy        = (state_q == StCalc) || (state_q == StConv);
    assign done        = done_q;
    assign err         = (state_q == StErr);

endmodule

// File: tb/tb_calc_core.sv
// Bench for calc_core (DIGITS=2): key-sequence table with a result scoreboard, plus
// hand-written chaining, error, abort and reset sequences.
module tb_calc_core;
    localparam int RW = 18;
    localparam int BL = 16;
    localparam int EQ = 18;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [39:0] seg_data;
    logic [7:0]  seg_data_en;
    logic [7:0]  seg_dot_en;
    logic        busy, done, err;

    calc_core #(.DIGITS(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .seg_data    (seg_data),
        .seg_data_en (seg_data_en),
        .seg_dot_en  (seg_dot_en),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] keys;
        logic [3:0]  nk;
        logic [39:0] seg;
        logic [7:0]  dot;
        logic        err;
    } vec_t;

    typedef struct packed {
        logic [39:0] seg;
        logic [7:0]  dot;
        logic        err;
    } exp_t;

    vec_t        vecs [14];
    exp_t        sb [$];
    int          n_tests = 0;
    int          n_fail = 0;
    logic [39:0] blank_seg;
    logic [39:0] err_seg;

    function automatic logic [39:0] seg8(input int d1, input int d2, input int d3, input int d4,
                                         input int d5, input int d6, input int d7, input int d8);
        return {5'(d8), 5'(d7), 5'(d6), 5'(d5), 5'(d4), 5'(d3), 5'(d2), 5'(d1)};
    endfunction

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    // Drives a key string (hex nibbles, first key leftmost); expectation queued with the last key.
    task automatic send(input logic [31:0] keys, input int nk, input exp_t e, input bit push);
        for (int i = 0; i < nk; i++) begin
            if (push && i == nk - 1) sb.push_back(e);
            press(keys[4*(nk-1-i) +: 4]);
        end
    endtask

    task automatic wait_result(input string name);
        int   cyc;
        bit   hit;
        exp_t e;
        cyc = 0;
        hit = 1'b0;
        while (!hit && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (done || err) hit = 1'b1;
        end
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = sb.pop_front();
        if (!hit) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no done/err within 100 cycles", name);
            return;
        end
        check({name, " seg"}, seg_data, e.seg);
        check({name, " dot"}, 40'(seg_dot_en), 40'(e.dot));
        check({name, " err"}, 40'(err), 40'(e.err));
        if (!e.err) begin
            check({name, " latency ok"}, 40'(cyc <= 2 * RW + 4), 40'(1));
            @(negedge clk);
            check({name, " done width"}, 40'(done), 40'(0));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   dcount;
        exp_t e;
        blank_seg = seg8(BL, BL, BL, BL, BL, BL, BL, BL);
        err_seg   = seg8(BL, BL, BL, BL, BL, 15, 17, 17);

        vecs[0]  = '{32'h47a58e, 4'd6, seg8(EQ, BL, BL, BL, BL, 1, 0, 5), 8'h00, 1'b0};
        vecs[1]  = '{32'h12b30e, 4'd6, seg8(EQ, BL, BL, BL, BL, 12, 1, 8), 8'h00, 1'b0};
        vecs[2]  = '{32'h99c99e, 4'd6, seg8(EQ, BL, BL, BL, 9, 8, 0, 1), 8'h00, 1'b0};
`ifdef CALC_DIV_FRAC_EN
        vecs[3]  = '{32'h7d2e, 4'd4, seg8(EQ, BL, BL, BL, BL, BL, 3, 5), 8'h40, 1'b0};
        vecs[8]  = '{32'h99d7e, 4'd5, seg8(EQ, BL, BL, BL, BL, 1, 4, 1), 8'h40, 1'b0};
        vecs[9]  = '{32'h1d3e, 4'd4, seg8(EQ, BL, BL, BL, BL, BL, 0, 3), 8'h40, 1'b0};
`else
        vecs[3]  = '{32'h7d2e, 4'd4, seg8(EQ, BL, BL, BL, BL, BL, BL, 3), 8'h00, 1'b0};
        vecs[8]  = '{32'h99d7e, 4'd5, seg8(EQ, BL, BL, BL, BL, BL, 1, 4), 8'h00, 1'b0};
        vecs[9]  = '{32'h1d3e, 4'd4, seg8(EQ, BL, BL, BL, BL, BL, BL, 0), 8'h00, 1'b0};
`endif
        vecs[4]  = '{32'h5d0e, 4'd4, err_seg, 8'h00, 1'b1};
        vecs[5]  = '{32'h3ac4e, 4'd5, seg8(EQ, BL, BL, BL, BL, BL, 1, 2), 8'h00, 1'b0};
        vecs[6]  = '{32'h0b0e, 4'd4, seg8(EQ, BL, BL, BL, BL, BL, BL, 0), 8'h00, 1'b0};
        vecs[7]  = '{32'h5b99e, 4'd5, seg8(EQ, BL, BL, BL, BL, 12, 9, 4), 8'h00, 1'b0};
        vecs[10] = '{32'ha5e, 4'd3, seg8(EQ, BL, BL, BL, BL, BL, BL, 5), 8'h00, 1'b0};
        vecs[11] = '{32'h123a1e, 4'd6, seg8(EQ, BL, BL, BL, BL, BL, 1, 3), 8'h00, 1'b0};
        vecs[12] = '{32'h07c11e, 4'd6, seg8(EQ, BL, BL, BL, BL, BL, 7, 7), 8'h00, 1'b0};
        vecs[13] = '{32'h6a3be, 4'd5, seg8(EQ, BL, BL, BL, BL, BL, BL, 9), 8'h00, 1'b0};

        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset seg", seg_data, blank_seg);
        check("reset seg_en", 40'(seg_data_en), 40'hff);
        check("reset dot", 40'(seg_dot_en), 40'h00);
        check("reset flags", 40'({busy, done, err}), 40'(0));

        for (int v = 0; v < 14; v++) begin
            e = '{vecs[v].seg, vecs[v].dot, vecs[v].err};
            press(4'hf);
            send(vecs[v].keys, int'(vecs[v].nk), e, 1'b1);
            wait_result($sformatf("vec%0d", v));
        end

        // Entry past DIGITS is ignored
        send(32'hf123, 4, '0, 1'b0);
        check("entry 123", seg_data, seg8(BL, BL, BL, BL, BL, BL, 1, 2));

        // New operand from SHOW, then clear
        send(32'hf99c99e, 7, '{seg8(EQ, BL, BL, BL, 9, 8, 0, 1), 8'h00, 1'b0}, 1'b1);
        wait_result("mul99");
        press(4'h7);
        check("show digit", seg_data, seg8(BL, BL, BL, BL, BL, BL, BL, 7));
        press(4'hf);
        check("clear seg", seg_data, blank_seg);
        check("clear busy", 40'(busy), 40'(0));

        // Chaining with operator replacement
        send(32'hf3ac4e, 6, '{seg8(EQ, BL, BL, BL, BL, BL, 1, 2), 8'h00, 1'b0}, 1'b1);
        wait_result("chain1");
        press(4'ha);
        check("chain op disp", seg_data, seg8(10, BL, BL, BL, BL, BL, 1, 2));
        send(32'h1e, 2, '{seg8(EQ, BL, BL, BL, BL, BL, 1, 3), 8'h00, 1'b0}, 1'b1);
        wait_result("chain2");

        // Chain from a divide uses the truncated quotient
`ifdef CALC_DIV_FRAC_EN
        e = '{seg8(EQ, BL, BL, BL, BL, BL, 3, 5), 8'h40, 1'b0};
`else
        e = '{seg8(EQ, BL, BL, BL, BL, BL, BL, 3), 8'h00, 1'b0};
`endif
        send(32'hf7d2e, 5, e, 1'b1);
        wait_result("divchain1");
        send(32'ha1e, 3, '{seg8(EQ, BL, BL, BL, BL, BL, BL, 4), 8'h00, 1'b0}, 1'b1);
        wait_result("divchain2");

        // Chaining an out-of-range or negative result is an error; only C exits
        send(32'hf99c2e, 6, '{seg8(EQ, BL, BL, BL, BL, 1, 9, 8), 8'h00, 1'b0}, 1'b1);
        wait_result("big");
        press(4'ha);
        check("chain big err", 40'(err), 40'(1));
        check("chain big seg", seg_data, err_seg);
        send(32'hf1b2e, 5, '{seg8(EQ, BL, BL, BL, BL, BL, 12, 1), 8'h00, 1'b0}, 1'b1);
        wait_result("neg");
        press(4'hb);
        check("chain neg err", 40'(err), 40'(1));
        press(4'h3);
        check("err sticky", 40'(err), 40'(1));
        press(4'hf);
        check("err cleared", 40'({err, seg_data}), 40'({1'b0, blank_seg}));

        // Reset in the middle of a multiply
        send(32'hf99c99e, 7, '0, 1'b0);
        repeat (3) @(negedge clk);
        check("mid calc busy", 40'(busy), 40'(1));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort flags", 40'({busy, done, err}), 40'(0));
        check("abort seg", seg_data, blank_seg);
        check("abort dot", 40'(seg_dot_en), 40'h00);

        // 'C' during conversion: no done pulse
        send(32'hf99c99e, 7, '0, 1'b0);
        repeat (10) @(negedge clk);
        check("mid conv busy", 40'(busy), 40'(1));
        press(4'hf);
        dcount = 0;
        repeat (50) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("conv abort done", 40'(dcount), 40'(0));
        check("conv abort idle", 40'({busy, seg_data}), 40'({1'b0, blank_seg}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
